// File: rtl/code_lock_pkg.sv
// Shared types and width helpers for the sequential combination lock.
package code_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTER   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    function automatic int fail_width(input int max_fail);
        return $clog2(max_fail + 1);
    endfunction

    function automatic int timer_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/code_lock_if.sv
// Digit entry, key update and status bundle between the lock and its user.
interface code_lock_if
    import code_lock_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DIGITS   = 4,
    parameter int MAX_FAIL = 3
) ();

    // Handshake: a digit transfers on a rising edge where digit_valid && digit_ready;
    // digit_ready depends only on registered state, and digit_valid is ignored while it is low.
    logic                          digit_valid;
    logic [WIDTH-1:0]              digit_in;
    logic                          digit_ready;
    logic                          relock;
    logic                          key_load;
    logic [WIDTH*DIGITS-1:0]       key_in;
    logic                          unlocked;
    logic                          error;
    logic                          locked_out;
    logic [fail_width(MAX_FAIL)-1:0] fail_count;
    state_e                        state_dbg;
    logic                          timer_busy_dbg;

    modport master (
        output digit_valid, digit_in, relock, key_load, key_in,
        input  digit_ready, unlocked, error, locked_out, fail_count,
        input  state_dbg, timer_busy_dbg
    );

    modport slave (
        input  digit_valid, digit_in, relock, key_load, key_in,
        output digit_ready, unlocked, error, locked_out, fail_count,
        output state_dbg, timer_busy_dbg
    );

endinterface

// File: rtl/lockout_timer.sv
// Loadable down-counter; expire flags the last cycle of a loaded interval.
module lockout_timer #(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          busy,
    output logic          expire
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy   = (count_q != '0);
    assign expire = (count_q == TW'(1));

endmodule

// File: rtl/code_lock_fsm.sv
// Combination lock: digit-serial code compare against a loadable key, with lockout after repeated failures.
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int                      WIDTH          = 4,
    parameter int                      DIGITS         = 4,
    parameter int                      MAX_FAIL       = 3,
    parameter int                      LOCKOUT_CYCLES = 16,
    parameter logic [WIDTH*DIGITS-1:0] RESET_KEY      = 16'h1234
) (
    input  logic        clk,
    input  logic        rst,
    code_lock_if.slave  bus
);

    localparam int IW = idx_width(DIGITS);
    localparam int FW = fail_width(MAX_FAIL);
    localparam int TW = timer_width(LOCKOUT_CYCLES);
    localparam int KW = WIDTH * DIGITS;

    if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
        $error("LOCKOUT_CYCLES must be at least 1");
    end

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            mismatch_q, mismatch_d;
    logic [KW-1:0]   key_q, key_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic            error_q, error_d;
    logic            timer_load;
    logic            timer_busy;
    logic            timer_expire;

    logic [WIDTH-1:0] key_digits [DIGITS];
    logic             accept;
    logic             digit_ne;
    logic             last_digit;
    logic [FW-1:0]    fail_inc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_key_split
        assign key_digits[g] = key_q[g*WIDTH +: WIDTH];
    end

    assign accept     = (state_q == ST_ENTER) && bus.digit_valid;
    assign digit_ne   = (bus.digit_in != key_digits[idx_q]);
    assign last_digit = (idx_q == IW'(DIGITS - 1));
    // fail_q is always below MAX_FAIL in ENTER, so the increment cannot wrap.
    assign fail_inc   = fail_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        key_d      = key_q;
        fail_d     = fail_q;
        error_d    = 1'b0;
        timer_load = 1'b0;

        unique case (state_q)
            ST_ENTER: begin
                if (accept) begin
                    if (last_digit) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        if (!(mismatch_q || digit_ne)) begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                        end else begin
                            error_d = 1'b1;
                            fail_d  = fail_inc;
                            if (fail_inc == FW'(MAX_FAIL)) begin
                                state_d    = ST_LOCKOUT;
                                timer_load = 1'b1;
                            end
                        end
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        mismatch_d = mismatch_q || digit_ne;
                    end
                end
            end
            ST_OPEN: begin
                if (bus.key_load) begin
                    key_d = bus.key_in;
                end
                if (bus.relock) begin
                    state_d = ST_ENTER;
                end
            end
            ST_LOCKOUT: begin
                if (timer_expire) begin
                    state_d = ST_ENTER;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = ST_ENTER;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ENTER;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            key_q      <= RESET_KEY;
            fail_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            key_q      <= key_d;
            fail_q     <= fail_d;
            error_q    <= error_d;
        end
    end

    lockout_timer #(
        .TW(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TW'(LOCKOUT_CYCLES)),
        .busy     (timer_busy),
        .expire   (timer_expire)
    );

    assign bus.digit_ready    = (state_q == ST_ENTER);
    assign bus.unlocked       = (state_q == ST_OPEN);
    assign bus.locked_out     = (state_q == ST_LOCKOUT);
    assign bus.error          = error_q;
    assign bus.fail_count     = fail_q;
    assign bus.state_dbg      = state_q;
    assign bus.timer_busy_dbg = timer_busy;

    a_fail_sat: assert property (@(posedge clk) disable iff (rst) fail_q <= FW'(MAX_FAIL));
    a_lockout_timed: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_LOCKOUT) |-> timer_busy);

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: directed scenarios plus random traffic against a code-level reference model.
module tb_code_lock_fsm;
    import code_lock_pkg::*;

    localparam int             WIDTH          = 4;
    localparam int             DIGITS         = 4;
    localparam int             MAX_FAIL       = 3;
    localparam int             LOCKOUT_CYCLES = 16;
    localparam int             KW             = WIDTH * DIGITS;
    localparam logic [KW-1:0]  RESET_KEY      = 16'h1234;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    code_lock_if #(.WIDTH(WIDTH), .DIGITS(DIGITS), .MAX_FAIL(MAX_FAIL)) bus ();

    code_lock_fsm #(
        .WIDTH          (WIDTH),
        .DIGITS         (DIGITS),
        .MAX_FAIL       (MAX_FAIL),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .RESET_KEY      (RESET_KEY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: digits collected so far, whole-code compare on the last one.
    logic [WIDTH-1:0] exp_q[$];
    logic [KW-1:0]    key_m;
    int               fails_m;
    int               lock_left_m;
    bit               open_m;
    bit               err_m;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        key_m       = RESET_KEY;
        fails_m     = 0;
        lock_left_m = 0;
        open_m      = 1'b0;
        err_m       = 1'b0;
    endtask

    task automatic model_edge();
        logic [KW-1:0] code;
        err_m = 1'b0;
        if (lock_left_m > 0) begin
            lock_left_m--;
            if (lock_left_m == 0) fails_m = 0;
        end else if (open_m) begin
            if (bus.key_load) key_m = bus.key_in;
            if (bus.relock) open_m = 1'b0;
        end else if (bus.digit_valid) begin
            exp_q.push_back(bus.digit_in);
            if (exp_q.size() == DIGITS) begin
                code = '0;
                for (int i = 0; i < DIGITS; i++) code[i*WIDTH +: WIDTH] = exp_q[i];
                exp_q.delete();
                if (code == key_m) begin
                    open_m  = 1'b1;
                    fails_m = 0;
                end else begin
                    err_m = 1'b1;
                    fails_m++;
                    if (fails_m == MAX_FAIL) lock_left_m = LOCKOUT_CYCLES;
                end
            end
        end
    endtask

    task automatic check_outputs();
        state_e st_exp;
        st_exp = (lock_left_m > 0) ? ST_LOCKOUT : (open_m ? ST_OPEN : ST_ENTER);
        check("unlocked",    32'(bus.unlocked),    32'(open_m));
        check("locked_out",  32'(bus.locked_out),  32'(lock_left_m > 0));
        check("digit_ready", 32'(bus.digit_ready), 32'(!open_m && lock_left_m == 0));
        check("error",       32'(bus.error),       32'(err_m));
        check("fail_count",  32'(bus.fail_count),  32'(fails_m));
        check("state_dbg",   32'(bus.state_dbg),   32'(st_exp));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.digit_valid = 1'b0;
        bus.digit_in    = '0;
        bus.relock      = 1'b0;
        bus.key_load    = 1'b0;
        bus.key_in      = '0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic send_code(input logic [KW-1:0] code);
        for (int i = 0; i < DIGITS; i++) begin
            bus.digit_valid = 1'b1;
            bus.digit_in    = code[i*WIDTH +: WIDTH];
            cycle();
        end
        bus.digit_valid = 1'b0;
    endtask

    task automatic do_relock();
        bus.relock = 1'b1;
        cycle();
        bus.relock = 1'b0;
    endtask

    initial begin
        int lo_cycles;
        idle_inputs();
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Correct reset key opens.
        send_code(16'h1234);
        check("open_on_key", 32'(bus.unlocked), 32'd1);
        check("open_fail0", 32'(bus.fail_count), 32'd0);
        do_relock();
        check("relock_ready", 32'(bus.digit_ready), 32'd1);

        // Two failures, the second mismatching on the first digit.
        send_code(16'h0234);
        check("err_pulse1", 32'(bus.error), 32'd1);
        check("fail1", 32'(bus.fail_count), 32'd1);
        send_code(16'h1230);
        check("err_pulse2", 32'(bus.error), 32'd1);

        // Third failure enters lockout; hold valid and key_load throughout.
        send_code(16'h5555);
        check("err_with_lockout", 32'(bus.error & bus.locked_out), 32'd1);
        lo_cycles = 1;
        bus.digit_valid = 1'b1;
        bus.digit_in    = 4'h4;
        bus.key_load    = 1'b1;
        bus.key_in      = 16'hFFFF;
        for (int i = 0; i < LOCKOUT_CYCLES + 4 && bus.locked_out; i++) begin
            cycle();
            if (bus.locked_out) lo_cycles++;
        end
        idle_inputs();
        check("lockout_len", 32'(lo_cycles), 32'(LOCKOUT_CYCLES));
        check("post_lock_fail0", 32'(bus.fail_count), 32'd0);

        // key_load outside OPEN is ignored.
        bus.key_load = 1'b1;
        bus.key_in   = 16'hFFFF;
        cycle();
        idle_inputs();
        send_code(16'h1234);
        check("key_kept", 32'(bus.unlocked), 32'd1);

        // Key load and relock together.
        bus.key_load = 1'b1;
        bus.relock   = 1'b1;
        bus.key_in   = 16'hA5C3;
        cycle();
        idle_inputs();
        send_code(16'h1234);
        check("old_key_err", 32'(bus.error), 32'd1);
        send_code(16'hA5C3);
        check("new_key_open", 32'(bus.unlocked), 32'd1);
        do_relock();

        // Reset mid-entry.
        bus.digit_valid = 1'b1;
        bus.digit_in    = 4'h4;
        cycle();
        cycle();
        idle_inputs();
        do_reset();
        send_code(16'h1234);
        check("open_after_rst", 32'(bus.unlocked), 32'd1);
        do_relock();

        // Reset mid-lockout.
        for (int k = 0; k < MAX_FAIL; k++) send_code(16'h9999);
        for (int i = 0; i < 5; i++) cycle();
        check("mid_lockout", 32'(bus.locked_out), 32'd1);
        do_reset();
        send_code(16'h1234);
        check("open_after_lo_rst", 32'(bus.unlocked), 32'd1);

        // Random traffic biased toward the current key.
        for (int n = 0; n < 3000; n++) begin
            int pos;
            pos = exp_q.size();
            bus.digit_valid = ($urandom_range(0, 3) != 0);
            bus.digit_in    = ($urandom_range(0, 4) != 0) ? key_m[pos*WIDTH +: WIDTH]
                                                          : WIDTH'($urandom);
            bus.relock      = ($urandom_range(0, 5) == 0);
            bus.key_load    = ($urandom_range(0, 7) == 0);
            bus.key_in      = KW'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                idle_inputs();
                do_reset();
            end else begin
                cycle();
            end
        end
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/code_lock_fsm.md
# code_lock_fsm

Sequential combination lock. It accepts a multi-digit code one nibble at a time over a valid/ready handshake and compares each digit against a stored key. It asserts `unlocked` only when every digit matches, and enforces a timed lockout after repeated failures. It is the stateful consumer that drives the nibble-wide equality checks used elsewhere in the lab designs.

## Interface
Parameters:
- `WIDTH`, 4: bits per digit.
- `DIGITS`, 4: digits per code.
- `MAX_FAIL`, 3: consecutive failed entries that trigger lockout.
- `LOCKOUT_CYCLES`, 16: lockout duration in clock cycles; must be ≥1.
- `RESET_KEY`, 16'h1234: key after reset, `WIDTH*DIGITS` bits; digit 0 is bits `[WIDTH-1:0]`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `digit_valid`, in, 1: `digit_in` is presented this cycle.
- `digit_in`, in, `WIDTH`: entered digit.
- `digit_ready`, out, 1: block accepts a digit this cycle.
- `relock`, in, 1: single-cycle request to leave OPEN.
- `key_load`, in, 1: capture `key_in`; honoured only in OPEN.
- `key_in`, in, `WIDTH*DIGITS`: new key.
- `unlocked`, out, 1: high while in OPEN.
- `error`, out, 1: one-cycle pulse on each failed complete entry.
- `locked_out`, out, 1: high while in LOCKOUT.
- `fail_count`, out, `$clog2(MAX_FAIL+1)`: consecutive failures.

## Operation
States:
- **ENTER** (reset state).
  - `digit_ready`=1.
  - A digit is accepted when `digit_valid && digit_ready`. It is compared with key digit `idx`.
  - A sticky `mismatch` flag ORs in any inequality. `idx` increments on each accepted digit.
- **Accepting digit `DIGITS-1`.**
  - No early abort: all `DIGITS` digits are always consumed before a verdict.
  - Match (no mismatch including this digit): go to OPEN and clear `fail_count`.
  - Otherwise: pulse `error` and increment `fail_count`.
  - If the new `fail_count` equals `MAX_FAIL`: go to LOCKOUT and load the timer with `LOCKOUT_CYCLES`. Otherwise stay in ENTER.
  - In all cases `idx` and `mismatch` clear.
- **OPEN.**
  - `unlocked`=1 and `digit_ready`=0.
  - `key_load` captures `key_in` into the key register.
  - `relock` goes to ENTER.
  - If both are asserted in the same cycle, the new key is captured and the state goes to ENTER.
- **LOCKOUT.**
  - `locked_out`=1 and `digit_ready`=0.
  - The timer decrements every cycle. On the cycle the timer reads 1, the next state is ENTER and `fail_count` clears.
- **Ignored inputs.**
  - `digit_valid` is ignored whenever `digit_ready`=0.
  - `key_load` and `relock` are ignored outside OPEN.
- **Reset, at any point including mid-entry or mid-lockout:**
  - State ENTER, `idx`=0, `mismatch`=0, key=`RESET_KEY`, timer=0, `fail_count`=0.
  - `unlocked`=0, `error`=0, `locked_out`=0.
  - `digit_ready`=1, because it is decoded from state.

## Timing
- `digit_ready`, `unlocked` and `locked_out` are decoded from registered state; no combinational path from inputs.
- Verdict latency is 1 cycle. `unlocked` or `error` is high in the cycle after the final digit is accepted.
- `error` is registered and high for exactly 1 cycle per failure.
- On the failure that reaches `MAX_FAIL`, `error` and `locked_out` rise in the same cycle.
- `locked_out` stays high for exactly `LOCKOUT_CYCLES` cycles, then `digit_ready` returns to 1.
- After `relock` in OPEN, `unlocked` falls and `digit_ready` rises in the next cycle.
- Back-to-back digits at full rate (`digit_valid` held high) are accepted one per cycle in ENTER.
- `fail_count` saturates by construction: it never exceeds `MAX_FAIL`.

## Structure
- Shared package/header `code_lock_pkg`:
  - State encodings `ST_ENTER`, `ST_OPEN`, `ST_LOCKOUT` (2-bit).
  - Width helpers for `idx`, `fail_count` and the timer (`$clog2`-based constants).
- Sub-module `lockout_timer`:
  - Inputs: `clk`, `rst`, `load`, `load_val`.
  - Outputs: `busy`, `expire` (high when count==1).
  - Loadable down-counter.
- The FSM, key register, digit index and comparison live in `code_lock_fsm`.

## Test plan
- Reset, then enter 4,3,2,1 (digit0=4 matches `RESET_KEY` 16'h1234 digit order) → `unlocked`=1 the cycle after the 4th digit, `fail_count`=0, `error` never pulses.
- Enter 4,3,2,0 → one-cycle `error`, `fail_count`=1, stay in ENTER with `digit_ready`=1. Then enter 0,3,2,1 (mismatch on the first digit) → all 4 digits are still consumed before `error`.
- Three wrong entries → 3rd `error` coincides with `locked_out` rising. `locked_out` stays high 16 cycles while `digit_valid` is held high with no digits accepted. Afterwards `fail_count`=0 and `digit_ready`=1.
- In OPEN, `key_load`=1 and `relock`=1 in the same cycle with `key_in`=16'hA5C3 → ENTER. Old code 4,3,2,1 gives `error`; code 3,C,5,A unlocks.
- Assert `rst` after 2 digits entered, and separately mid-lockout → all outputs at reset values immediately. A full correct code then unlocks with no residual `idx` or `fail_count`.
- `key_load` asserted in ENTER and in LOCKOUT → key unchanged (`RESET_KEY` code still unlocks).
